// File: rtl/spoofer_stream_arbiter.sv
// Round-robin burst arbiter: grants one AVST source at a time and forwards up to
// BURST_LEN beats through a registered output stage tagged with channel and end-of-burst.
module spoofer_stream_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 4,
  parameter int GAP_TIMEOUT = 2,
  localparam int CH_WIDTH   = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            in_req,
  input  logic [NUM_SRC-1:0]            in_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
  output logic [NUM_SRC-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CH_WIDTH-1:0]           out_channel,
  output logic                          out_eop,
  input  logic                          out_ready
);

  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam int GC_W = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [CH_WIDTH-1:0]     grant_q, grant_d;
  logic [CH_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic [GC_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CH_WIDTH-1:0]     out_channel_q, out_channel_d;
  logic                    out_eop_q, out_eop_d;

  logic                    found;
  logic [CH_WIDTH-1:0]     pick;
  logic                    src_valid;
  logic                    src_req;
  logic [DATA_WIDTH-1:0]   src_data;
  logic                    out_free;
  logic                    xfer;
  logic                    last_beat;
  logic [CH_WIDTH-1:0]     next_ptr;

  // First requester at or after rr_ptr, wrapping around the source list.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && in_req[(int'(rr_ptr_q) + k) % NUM_SRC]) begin
        found = 1'b1;
        pick  = CH_WIDTH'((int'(rr_ptr_q) + k) % NUM_SRC);
      end
    end
  end

  assign src_valid = in_valid[grant_q];
  assign src_req   = in_req[grant_q];
  assign src_data  = in_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign out_free  = !out_valid_q || out_ready;
  assign xfer      = (state_q == BURST) && src_valid && out_free;
  assign last_beat = (beat_cnt_q == BC_W'(BURST_LEN - 1));
  assign next_ptr  = (grant_q == CH_WIDTH'(NUM_SRC - 1)) ? '0 : grant_q + CH_WIDTH'(1);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
    assign in_ready[gi] = (state_q == BURST) && (grant_q == CH_WIDTH'(gi)) && out_free;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_eop_d     = out_eop_q;

    if (xfer) begin
      out_valid_d   = 1'b1;
      out_data_d    = src_data;
      out_channel_d = grant_q;
      out_eop_d     = last_beat;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_eop_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BC_W'(1);
          gap_cnt_d  = '0;
          if (last_beat || !src_req) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else begin
          // A stalled-but-valid source holds gap_cnt: backpressure is not idleness.
          if (!src_valid) gap_cnt_d = gap_cnt_q + GC_W'(1);
          if (!src_req || (!src_valid && gap_cnt_q == GC_W'(GAP_TIMEOUT - 1))) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_eop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_eop_q     <= out_eop_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_eop     = out_eop_q;

endmodule
